mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-port unified memory between the pipeline's fetch (IF) and data (MEM) stages.
// - Sequences one outstanding memory transaction at a time.
// - Drives the stall requests that the pipeline control ORs into its StallF/StallD/StallE/StallM.
// - Discards fetch responses killed by a taken branch/jump flush.
// PARAMETERS
// - AW       32   address width (byte address)
// - DW       32   data width
// - TIMEOUT  64   cycles in WAIT before bus_err is raised; legal range >=2
// PORTS
// - clk          in   1      rising-edge clock
// - rst_n        in   1      asynchronous active-low reset
// - if_req       in   1      fetch wants instruction at if_addr; held until if_valid or flush
// - if_addr      in   AW     fetch address (PCF)
// - if_flush     in   1      PCSrcE: kill any in-flight fetch
// - if_valid     out  1      one-cycle pulse, if_rdata valid
// - if_rdata     out  DW     instruction word
// - dm_req       in   1      load/store request; held until dm_valid
// - dm_we        in   1      1 = store
// - dm_be        in   DW/8   store byte enables
// - dm_addr      in   AW     data address (ALUResultM)
// - dm_wdata     in   DW     store data
// - dm_valid     out  1      one-cycle pulse, access complete (dm_rdata valid for loads)
// - dm_rdata     out  DW     load data
// - stall_fetch  out  1      if_req & ~if_valid (combinational)
// - stall_mem    out  1      dm_req & ~dm_valid (combinational); freezes F..M stages
// - mem_req      out  1      memory request, held until mem_gnt
// - mem_we       out  1      write
// - mem_be       out  DW/8   byte enables (all ones for reads)
// - mem_addr     out  AW     address
// - mem_wdata    out  DW     write data
// - mem_gnt      in   1      memory accepted request this cycle
// - mem_rvalid   in   1      response (reads and writes), mem_rdata valid
// - mem_rdata    in   DW     read data
// - bus_err      out  1      sticky: WAIT exceeded TIMEOUT; cleared only by reset
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, drop=0, tmo_cnt=0.
//   - Reset also forces every output to 0: mem_*, if_valid, dm_valid, both rdata, bus_err.
// - FSM IDLE -> REQ -> WAIT -> IDLE. Owner register: OWN_IF / OWN_DM.
//   - IDLE: dm_req wins over if_req (older instruction). Selected request is latched into
//     mem_* registers; goto REQ. Equal req on both -> DM first, IF next.
//   - REQ: mem_req=1. Address/data/we/be are stable and held while mem_gnt=0.
//     mem_gnt=1 -> mem_req drops next cycle; goto WAIT.
//   - WAIT: tmo_cnt counts up. mem_rvalid=1 -> goto IDLE and register the response.
//     - OWN_DM: dm_valid pulse. OWN_IF & ~drop: if_valid pulse. OWN_IF & drop: no pulse.
//     - mem_rvalid arriving in REQ is ignored (protocol violation; assertion).
// - Latency, zero-wait memory (gnt in REQ's first cycle, rvalid first cycle of WAIT):
//   req seen cycle 0 -> mem_req cycles 1 -> valid pulse cycle 3.
// - Back-to-back: valid pulse cycle coincides with IDLE. Next request launches from IDLE then.
//   The requester drops/changes its req the cycle after its valid, so no duplicate issue.
// - Flush: if_flush while OWN_IF in REQ/WAIT sets drop.
//   - mem_req is never withdrawn before gnt; the killed fetch completes silently.
//   - drop clears on return to IDLE. if_flush in IDLE or while OWN_DM: no effect.
//   - Flush coincident with rvalid: response dropped.
// - Timeout: tmo_cnt==TIMEOUT-1 in WAIT -> bus_err=1. FSM keeps waiting; no recovery.
// - Writes: mem_rdata ignored; dm_rdata holds its previous value.
// - if_rdata/dm_rdata update only on their own valid pulse.
// STRUCTURE
// - Package mem_arb_pkg holds:
//   - arb_state_t {IDLE,REQ,WAIT}
//   - owner_t {OWN_IF,OWN_DM}
//   - localparam BE_ALL
// - Sub-module mem_arb_timeout: TIMEOUT-parameterised counter.
//   - Inputs: clear, enable. Output: sticky expired.
// - Everything else in one always_ff (state + mem_* + response regs) plus one always_comb
//   (next state, stalls).
// TESTING
// - Single fetch, if_addr=0x0000_0040, gnt+rvalid zero-wait, rdata=0x0051_0113
//   -> if_valid cycle 3, if_rdata=0x0051_0113, stall_fetch high cycles 0-2.
// - if_req and dm_req both rise cycle 0 (lw @0x100 -> 0xDEAD_BEEF)
//   -> mem_addr=0x100 first, dm_valid first; fetch issued after, both pulses exactly once.
// - Store dm_we=1, dm_be=4'b0011, wdata=0x1234_5678, gnt delayed 3 cycles
//   -> mem_* stable through the delay, mem_req drops after gnt, dm_valid on rvalid.
// - Fetch in WAIT, if_flush pulses, rvalid 2 cycles later
//   -> no if_valid. A new if_req at 0x200 issues afterward and returns normally.
// - rvalid withheld 64 cycles (TIMEOUT=64) -> bus_err=1 at count 63 and stays;
//   rst_n low mid-WAIT -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

  // Wide enough for any DW up to 1024; the top slices it down to DW/8.
  localparam logic [127:0] BE_ALL = '1;

endpackage

// File: rtl/mem_arb_timeout.sv
// rtl/mem_arb_timeout.sv - saturating wait counter with a sticky expiry flag
module mem_arb_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // The count saturates on the last value; only reset clears the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == LAST) expired <= 1'b1;
      else             cnt     <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and data stages
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_flush,
  output logic            if_valid,
  output logic [DW-1:0]   if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [DW/8-1:0] dm_be,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  output logic            dm_valid,
  output logic [DW-1:0]   dm_rdata,
  output logic            stall_fetch,
  output logic            stall_mem,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            bus_err
);

  arb_state_t state, state_next;
  owner_t     owner;
  logic       drop;
  logic       launch_dm, launch_if;
  logic       in_wait;

  mem_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (~in_wait),
    .enable  (in_wait),
    .expired (bus_err)
  );

  // Stalls double as the launch condition, so a requester whose valid is
  // pulsing right now cannot be re-issued before it drops its request.
  always_comb begin
    stall_fetch = if_req & ~if_valid;
    stall_mem   = dm_req & ~dm_valid;
    in_wait     = (state == WAIT);
    state_next  = state;
    launch_dm   = 1'b0;
    launch_if   = 1'b0;
    case (state)
      IDLE: begin
        if (stall_mem) begin
          launch_dm  = 1'b1;
          state_next = REQ;
        end else if (stall_fetch) begin
          launch_if  = 1'b1;
          state_next = REQ;
        end
      end
      REQ:     if (mem_gnt) state_next = WAIT;
      WAIT:    if (mem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      drop      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_valid  <= 1'b0;
      dm_rdata  <= '0;
    end else begin
      state    <= state_next;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (launch_dm) begin
            owner     <= OWN_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_be    <= dm_we ? dm_be : BE_ALL[DW/8-1:0];
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else if (launch_if) begin
            owner     <= OWN_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= BE_ALL[DW/8-1:0];
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end
        end
        REQ: begin
          if (mem_gnt) mem_req <= 1'b0;
          if (owner == OWN_IF && if_flush) drop <= 1'b1;
        end
        WAIT: begin
          if (owner == OWN_IF && if_flush) drop <= 1'b1;
          if (mem_rvalid) begin
            drop <= 1'b0;
            if (owner == OWN_DM) begin
              dm_valid <= 1'b1;
              if (!mem_we) dm_rdata <= mem_rdata;
            end else if (!(drop || if_flush)) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A response before the grant has nowhere to go; it is ignored but flagged.
  a_rvalid_in_req: assert property (@(posedge clk) disable iff (!rst_n)
    !(state == REQ && mem_rvalid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW = 32, DW = 32, TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic if_req, if_flush, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic dm_req, dm_we, dm_valid;
  logic [3:0] dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic stall_fetch, stall_mem;
  logic mem_req, mem_we, mem_gnt, mem_rvalid, bus_err;
  logic [3:0] mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .stall_fetch(stall_fetch), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Memory environment (slave) and the bench's own reference memory.
  logic [31:0] smem [256];
  logic [31:0] rmem [256];
  int gnt_dly = 0, rsp_dly = 0;
  int ph = 0, scnt = 0, cur_gd = 0, cur_rd = 0;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_be;
  logic        c_we;
  int stab_err = 0, proto_err = 0;
  logic [31:0] glog_addr [$];
  logic        glog_we [$];
  logic [3:0]  glog_be [$];

  function automatic logic [31:0] init_word(input logic [7:0] i);
    return {8'h5A, i, ~i, i ^ 8'h3C};
  endfunction

  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!rst_n) ph = 0;
      else begin
        if (ph == 0 && mem_req) begin
          ph = 1; scnt = 0; cur_gd = gnt_dly; cur_rd = rsp_dly;
          c_addr = mem_addr; c_we = mem_we; c_be = mem_be; c_wdata = mem_wdata;
        end
        if (ph == 1) begin
          if (!mem_req || mem_addr !== c_addr || mem_we !== c_we ||
              mem_be !== c_be || mem_wdata !== c_wdata) stab_err++;
          if (scnt == cur_gd) begin
            mem_gnt = 1'b1; ph = 2; scnt = 0;
            glog_addr.push_back(c_addr); glog_we.push_back(c_we); glog_be.push_back(c_be);
          end else scnt++;
        end else if (ph == 2) begin
          if (mem_req) proto_err++;
          if (scnt == cur_rd) begin
            mem_rvalid = 1'b1; ph = 0;
            if (c_we) begin
              for (int b = 0; b < 4; b++)
                if (c_be[b]) smem[c_addr[9:2]][b*8 +: 8] = c_wdata[b*8 +: 8];
              mem_rdata = 32'hBAD0_BAD0;
            end else mem_rdata = smem[c_addr[9:2]];
          end else scnt++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive_idle();
    if_req = 0; if_addr = 0; if_flush = 0;
    dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
  endtask

  task automatic clear_log();
    glog_addr.delete(); glog_we.delete(); glog_be.delete();
  endtask

  task automatic set_word(input int idx, input logic [31:0] w);
    smem[idx] = w; rmem[idx] = w;
  endtask

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gd;
    int          rd;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  // Runs one isolated transaction starting at the current cycle (cycle 0).
  task automatic do_txn(input vec_t v, output int lat, output int stall_bad);
    lat = -1; stall_bad = 0;
    gnt_dly = v.gd; rsp_dly = v.rd;
    if (v.is_dm) begin
      dm_req = 1; dm_we = v.we; dm_be = v.be; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1; if_addr = v.addr;
    end
    for (int c = 0; c < 200; c++) begin
      #1;
      if (v.is_dm ? dm_valid : if_valid) begin
        lat = c;
        if (v.is_dm ? stall_mem : stall_fetch) stall_bad++;
        break;
      end
      if (!(v.is_dm ? stall_mem : stall_fetch)) stall_bad++;
      cyc();
    end
    cyc(); drive_idle(); cyc();
  endtask

  vec_t vt [6];
  int lat, sb;
  int dmc, ifc, dmcyc, ifcyc;
  logic [31:0] model_dm, model_if;

  initial begin
    rst_n = 0; drive_idle();
    for (int i = 0; i < 256; i++) set_word(i, init_word(8'(i)));
    set_word(16, 32'h0051_0113);
    set_word(17, 32'h0000_0013);
    set_word(64, 32'hDEAD_BEEF);
    set_word(128, 32'hCAFE_F00D);

    vt[0] = '{1'b0, 1'b0, 4'h0, 32'h40,  32'h0,         0, 0, 32'h0051_0113, 3};
    vt[1] = '{1'b1, 1'b0, 4'h0, 32'h100, 32'h0,         0, 0, 32'hDEAD_BEEF, 3};
    vt[2] = '{1'b1, 1'b1, 4'h3, 32'h100, 32'h1234_5678, 3, 0, 32'hDEAD_BEEF, 6};
    vt[3] = '{1'b1, 1'b0, 4'h0, 32'h100, 32'h0,         0, 2, 32'hDEAD_5678, 5};
    vt[4] = '{1'b0, 1'b0, 4'h0, 32'h44,  32'h0,         1, 1, 32'h0000_0013, 5};
    vt[5] = '{1'b1, 1'b0, 4'h0, 32'h200, 32'h0,         2, 3, 32'hCAFE_F00D, 8};

    repeat (3) cyc();
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_if_valid", 32'(if_valid), 0);
    check("rst_dm_valid", 32'(dm_valid), 0);
    check("rst_bus_err", 32'(bus_err), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    rst_n = 1;
    cyc();

    // Table of isolated transactions.
    for (int i = 0; i < 6; i++) begin
      clear_log();
      do_txn(vt[i], lat, sb);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
      check($sformatf("vec%0d_stall", i), 32'(sb), 0);
      check($sformatf("vec%0d_rdata", i), vt[i].is_dm ? dm_rdata : if_rdata, vt[i].exp_rdata);
      check($sformatf("vec%0d_issues", i), 32'(glog_addr.size()), 1);
      if (glog_addr.size() == 1) begin
        check($sformatf("vec%0d_addr", i), glog_addr[0], vt[i].addr);
        check($sformatf("vec%0d_we", i), 32'(glog_we[0]), 32'(vt[i].is_dm & vt[i].we));
        check($sformatf("vec%0d_be", i), 32'(glog_be[0]),
              (vt[i].is_dm && vt[i].we) ? 32'(vt[i].be) : 32'hF);
      end
    end

    // Simultaneous requests: DM first, IF right after, one pulse each.
    set_word(64, 32'hDEAD_BEEF);
    clear_log(); gnt_dly = 0; rsp_dly = 0;
    dm_req = 1; dm_we = 0; dm_addr = 32'h100; if_req = 1; if_addr = 32'h40;
    dmc = 0; ifc = 0; dmcyc = -1; ifcyc = -1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (dm_valid) begin dmc++; dmcyc = c; end
      if (if_valid) begin ifc++; ifcyc = c; end
      cyc();
      if (dmc > 0) dm_req = 0;
      if (ifc > 0) if_req = 0;
    end
    check("both_dm_pulses", 32'(dmc), 1);
    check("both_if_pulses", 32'(ifc), 1);
    check("both_dm_cycle", 32'(dmcyc), 3);
    check("both_if_cycle", 32'(ifcyc), 6);
    check("both_issues", 32'(glog_addr.size()), 2);
    if (glog_addr.size() == 2) begin
      check("both_first_addr", glog_addr[0], 32'h100);
      check("both_second_addr", glog_addr[1], 32'h40);
    end
    check("both_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    check("both_if_rdata", if_rdata, 32'h0051_0113);

    // Flush in WAIT: killed fetch completes silently, the next one returns.
    drive_idle(); clear_log(); gnt_dly = 0; rsp_dly = 3;
    ifc = 0; ifcyc = -1;
    for (int c = 0; c < 20; c++) begin
      if (c == 0) begin if_req = 1; if_addr = 32'h40; end
      if (c == 3) if_flush = 1;
      if (c == 4) begin if_flush = 0; if_addr = 32'h200; rsp_dly = 0; end
      #1;
      if (if_valid) begin ifc++; ifcyc = c; end
      cyc();
      if (ifc > 0) if_req = 0;
    end
    check("flush_if_pulses", 32'(ifc), 1);
    check("flush_if_cycle", 32'(ifcyc), 9);
    check("flush_if_rdata", if_rdata, 32'hCAFE_F00D);
    check("flush_issues", 32'(glog_addr.size()), 2);
    if (glog_addr.size() == 2) check("flush_second_addr", glog_addr[1], 32'h200);

    // Flush coincident with rvalid drops the response.
    drive_idle(); clear_log(); rsp_dly = 0; ifc = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin if_req = 1; if_addr = 32'h40; end
      if (c == 2) if_flush = 1;
      if (c == 3) begin if_flush = 0; if_req = 0; end
      #1;
      if (if_valid) ifc++;
      cyc();
    end
    check("flushrv_if_pulses", 32'(ifc), 0);
    check("flushrv_if_rdata", if_rdata, 32'hCAFE_F00D);

    // Flush during a data access has no effect.
    drive_idle(); rsp_dly = 1; dmc = 0; dmcyc = -1;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin dm_req = 1; dm_we = 0; dm_addr = 32'h100; end
      if (c == 2) if_flush = 1;
      if (c == 3) if_flush = 0;
      #1;
      if (dm_valid) begin dmc++; dmcyc = c; end
      cyc();
      if (dmc > 0) dm_req = 0;
    end
    check("flushdm_cycle", 32'(dmcyc), 4);
    check("flushdm_pulses", 32'(dmc), 1);

    // Timeout, then asynchronous reset mid-WAIT.
    drive_idle(); gnt_dly = 0; rsp_dly = 1000;
    if_req = 1; if_addr = 32'h40;
    for (int c = 0; c <= 80; c++) begin
      #1;
      if (c == 65) check("tmo_before", 32'(bus_err), 0);
      if (c == 66) check("tmo_at", 32'(bus_err), 1);
      if (c == 80) check("tmo_sticky", 32'(bus_err), 1);
      if (c < 80) cyc();
    end
    #2 rst_n = 0;
    #1;
    check("arst_mem_req", 32'(mem_req), 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_mem_be", 32'(mem_be), 0);
    check("arst_bus_err", 32'(bus_err), 0);
    check("arst_if_rdata", if_rdata, 0);
    check("arst_dm_rdata", dm_rdata, 0);
    drive_idle(); rsp_dly = 0;
    repeat (2) cyc();
    rst_n = 1; cyc();
    clear_log();
    vt[0].exp_rdata = 32'h0051_0113;
    do_txn(vt[0], lat, sb);
    check("post_rst_latency", 32'(lat), 3);
    check("post_rst_if_rdata", if_rdata, 32'h0051_0113);

    // Randomized traffic against the reference memory.
    model_if = 32'h0051_0113;
    model_dm = 32'h0;
    for (int t = 0; t < 150; t++) begin
      int mode;
      logic do_if, do_dm, we;
      logic [31:0] ia, da, wd, exp_dm, exp_if;
      logic [3:0] be;
      mode = $urandom_range(0, 2);
      do_if = (mode != 1); do_dm = (mode != 0);
      ia = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
      da = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(1, 15));
      wd = $urandom;
      gnt_dly = $urandom_range(0, 3); rsp_dly = $urandom_range(0, 3);
      // Data access is served first, so the fetch sees its store.
      if (do_dm) begin
        if (we) begin
          for (int b = 0; b < 4; b++) if (be[b]) rmem[da[9:2]][b*8 +: 8] = wd[b*8 +: 8];
        end else model_dm = rmem[da[9:2]];
      end
      if (do_if) model_if = rmem[ia[9:2]];
      exp_dm = model_dm; exp_if = model_if;
      if_req = do_if; if_addr = ia;
      dm_req = do_dm; dm_we = we; dm_be = be; dm_addr = da; dm_wdata = wd;
      dmc = 0; ifc = 0; dmcyc = -1; ifcyc = -1;
      for (int c = 0; c < 60; c++) begin
        #1;
        if (dm_valid) begin dmc++; dmcyc = c; end
        if (if_valid) begin ifc++; ifcyc = c; end
        cyc();
        if (dmc > 0) dm_req = 0;
        if (ifc > 0) if_req = 0;
      end
      check($sformatf("rnd%0d_dm_pulses", t), 32'(dmc), 32'(do_dm));
      check($sformatf("rnd%0d_if_pulses", t), 32'(ifc), 32'(do_if));
      if (do_dm) check($sformatf("rnd%0d_dm_rdata", t), dm_rdata, exp_dm);
      if (do_if) check($sformatf("rnd%0d_if_rdata", t), if_rdata, exp_if);
      if (do_dm && do_if) check($sformatf("rnd%0d_order", t), 32'(dmcyc < ifcyc), 1);
      drive_idle();
    end
    check("mem_stable_while_req", 32'(stab_err), 0);
    check("mem_req_drop_after_gnt", 32'(proto_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
